hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and memory-stall controller for a five-stage
// RV32I core. It produces stage-register load enables, bubble/NOP flush
// strobes and gated cache request strobes. Every control output is a
// combinational function of the current inputs and the registered
// done flags, so a decision takes effect in the same cycle.
// Two performance counters track frozen cycles and inserted load-use bubbles.

module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_access,
  input  logic        dmem_resp,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] freeze_cnt,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Sticky "this side already answered" flags. A side whose response
  // arrived while the other side is still pending must not be re-requested.
  logic imem_done_q;
  logic dmem_done_q;
  logic imem_done_next;
  logic dmem_done_next;

  logic i_pend;
  logic d_pend;
  logic mem_wait;
  logic load_use;
  logic bubble_inc;

  // Load-use detection: an EX-stage load writing a register that the ID
  // instruction reads. Writes to x0 are discarded, so they never hazard.
  function automatic logic load_use_hit(
    input logic       is_load,
    input logic [4:0] rd,
    input logic       uses_rs1,
    input logic [4:0] rs1,
    input logic       uses_rs2,
    input logic [4:0] rs2
  );
    logic match1;
    logic match2;
    match1 = uses_rs1 & (rd == rs1);
    match2 = uses_rs2 & (rd == rs2);
    return is_load & (rd != 5'd0) & (match1 | match2);
  endfunction

  // Pending-memory and hazard decode from the current inputs and done flags.
  always_comb begin
    i_pend   = imem_read & ~imem_done_q & ~imem_resp;
    d_pend   = dmem_access & ~dmem_done_q & ~dmem_resp;
    mem_wait = i_pend | d_pend;
    load_use = load_use_hit(ex_is_load, ex_rd, id_uses_rs1, id_rs1,
                            id_uses_rs2, id_rs2);
    // A bubble is only inserted when neither a freeze nor a redirect wins.
    bubble_inc = ~mem_wait & ~ex_br_taken & load_use;
  end

  // Output decision: reset > memory freeze > taken redirect > load-use > run.
  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      // Everything quiet while reset is held.
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end else begin
      imem_req = imem_read & ~imem_done_q;
      dmem_req = dmem_access & ~dmem_done_q;
      if (mem_wait) begin
        // Whole pipeline holds; EX keeps any pending redirect for later.
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
      end else if (ex_br_taken) begin
        // Redirect: the two younger instructions are on the wrong path.
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX. The bubble
        // clears ex_is_load next cycle, so the stall lasts exactly one cycle.
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        flush_id_ex = 1'b1;
      end else begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
    end
  end

  // Next-state and done-flag logic for the RUN/FREEZE machine.
  always_comb begin
    state_next     = state;
    imem_done_next = imem_done_q;
    dmem_done_next = dmem_done_q;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_next = FREEZE;
        end else begin
          state_next = RUN;
        end
      end
      FREEZE: begin
        if (mem_wait) begin
          state_next = FREEZE;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (mem_wait) begin
      // Remember whichever side answered so it is not asked again.
      imem_done_next = imem_done_q | imem_resp;
      dmem_done_next = dmem_done_q | dmem_resp;
    end else begin
      // Stages advance this cycle; the next access starts fresh.
      imem_done_next = 1'b0;
      dmem_done_next = 1'b0;
    end
  end

  // State and done-flag registers; reset discards any partial completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      imem_done_q <= imem_done_next;
      dmem_done_q <= dmem_done_next;
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze_cnt <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (mem_wait) begin
        freeze_cnt <= freeze_cnt + 32'd1;
      end else begin
        freeze_cnt <= freeze_cnt;
      end
      if (bubble_inc) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies one stimulus vector per
// cycle and pushes the reference model's expectation; a monitor pops and
// compares on the falling edge.

module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
  logic        imem_read, imem_resp, dmem_access, dmem_resp;
  logic        imem_req, dmem_req, load_pc, load_if_id, load_id_ex;
  logic        load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex;
  logic [31:0] freeze_cnt, bubble_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_access(dmem_access), .dmem_resp(dmem_resp),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .freeze_cnt(freeze_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       ir;
    logic       irsp;
    logic       da;
    logic       drsp;
  } stim_t;

  // ctl order: imem_req dmem_req load_pc load_if_id load_id_ex load_ex_mem
  //            load_mem_wb flush_if_id flush_id_ex
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: which cache side already answered, and counts.
  bit          m_i_done = 1'b0;
  bit          m_d_done = 1'b0;
  int unsigned m_freezes = 0;
  int unsigned m_bubbles = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the response, advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit want_i, want_d, stalled, hazard;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_rd = s.rd;
    ex_is_load = s.ld; ex_br_taken = s.br;
    imem_read = s.ir; imem_resp = s.irsp; dmem_access = s.da; dmem_resp = s.drsp;

    want_i  = s.ir && !m_i_done;
    want_d  = s.da && !m_d_done;
    stalled = (want_i && !s.irsp) || (want_d && !s.drsp);
    hazard  = s.ld && (s.rd != 5'd0) &&
              ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
    e.fc = m_freezes;
    e.bc = m_bubbles;
    if (s.rst)              e.ctl = 9'b00_00000_00;
    else if (stalled)       e.ctl = {want_i, want_d, 7'b00000_00};
    else if (s.br)          e.ctl = {want_i, want_d, 7'b11111_11};
    else if (hazard)        e.ctl = {want_i, want_d, 7'b00111_01};
    else                    e.ctl = {want_i, want_d, 7'b11111_00};
    sbq.push_back(e);

    if (s.rst) begin
      m_i_done = 1'b0; m_d_done = 1'b0; m_freezes = 0; m_bubbles = 0;
    end else if (stalled) begin
      m_freezes++;
      if (s.irsp) m_i_done = 1'b1;
      if (s.drsp) m_d_done = 1'b1;
    end else begin
      m_i_done = 1'b0; m_d_done = 1'b0;
      if (!s.br && hazard) m_bubbles++;
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("ctl", {23'd0, imem_req, dmem_req, load_pc, load_if_id, load_id_ex,
                      load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex},
              {23'd0, e.ctl});
        check("freeze_cnt", freeze_cnt, e.fc);
        check("bubble_cnt", bubble_cnt, e.bc);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; dmem_access = 1'b0; dmem_resp = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state with busy inputs: everything forced low.
    s = idle(); s.rst = 1'b1; s.ir = 1'b1; s.da = 1'b1; s.br = 1'b1; apply(s);
    s = idle(); apply(s);

    // Load-use hazard on rs1, then the bubble clears the load.
    s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; apply(s);
    s = idle(); apply(s);
    // Same with ex_rd = x0: no stall.
    s = idle(); s.ld = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1; apply(s);
    s = idle(); apply(s);
    // rs2 match but rs2 not used: no stall; used: stall.
    s = idle(); s.ld = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; apply(s);
    s.u2 = 1'b1; apply(s);
    s = idle(); apply(s);

    // Split responses: I answers in cycle 2, D in cycle 5.
    for (int c = 1; c <= 5; c++) begin
      s = idle(); s.ir = 1'b1; s.da = 1'b1;
      s.irsp = (c == 2); s.drsp = (c == 5);
      apply(s);
    end
    s = idle(); apply(s);

    // Redirect together with a load-use hazard: redirect wins.
    s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1; s.br = 1'b1; apply(s);
    s = idle(); apply(s);

    // Redirect held during a D-side freeze; flush only on the response cycle.
    for (int c = 1; c <= 4; c++) begin
      s = idle(); s.br = 1'b1; s.da = 1'b1; s.drsp = (c == 4);
      apply(s);
    end
    s = idle(); apply(s);

    // Reset in the middle of an I-freeze after a D response was recorded.
    s = idle(); s.ir = 1'b1; s.da = 1'b1; s.drsp = 1'b1; apply(s);
    s = idle(); s.ir = 1'b1; s.da = 1'b1; apply(s);
    s = idle(); s.rst = 1'b1; s.ir = 1'b1; s.da = 1'b1; apply(s);
    apply(s);
    s = idle(); s.ir = 1'b1; s.da = 1'b1; apply(s);
    s.irsp = 1'b1; s.drsp = 1'b1; apply(s);
    s = idle(); apply(s);

    // Randomized traffic biased toward register collisions.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 63) == 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.ld   = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 5) == 0);
      s.ir   = 1'($urandom_range(0, 1));
      s.irsp = ($urandom_range(0, 2) == 0);
      s.da   = ($urandom_range(0, 2) == 0);
      s.drsp = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    // Drain the scoreboard, bounded.
    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(negedge clk);
    if (sbq.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
